// File: rtl/spi_cfg_pkg.sv
// ---------------------------------------------------------------------------
// spi_cfg_pkg
// Shared definitions for the SPI configuration controller slice: default
// field widths of the 16-bit write frame, the write flag that leads every
// frame, the controller state encoding, and the register map of the PWM
// peripheral that this controller programs.
// ---------------------------------------------------------------------------
package spi_cfg_pkg;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;

  // Leading bit of every frame; the peripheral only accepts writes.
  localparam logic WRITE_BIT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  // Peripheral register map.
  localparam logic [ADDR_W-1:0] EN_REG_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] EN_REG_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] EN_REG_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] EN_REG_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] PWM_DUTY_CYCLE  = 7'h04;

endpackage

// File: rtl/spi_cfg_controller_if.sv
// ---------------------------------------------------------------------------
// spi_cfg_controller_if
// Bundles the request handshake, the SPI pins and the status flags of the
// configuration controller.
//   req_valid/req_addr/req_data : write request from the requester
//   req_ready                   : controller idle, request taken on valid&ready
//   sclk/ncs/copi               : SPI mode-0 pins toward the peripheral
//   busy/done                   : frame in progress / one-cycle completion
// The controller uses the slave modport, the requester the master modport.
// ---------------------------------------------------------------------------
interface spi_cfg_controller_if #(
  parameter int ADDR_W = spi_cfg_pkg::ADDR_W,
  parameter int DATA_W = spi_cfg_pkg::DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              sclk;
  logic              ncs;
  logic              copi;
  logic              busy;
  logic              done;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, sclk, ncs, copi, busy, done
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, sclk, ncs, copi, busy, done
  );

endinterface

// File: rtl/spi_half_period_timer.sv
// ---------------------------------------------------------------------------
// spi_half_period_timer
// Free-running CLK_DIV divider that paces every timed state of the
// controller. Counts 0..CLK_DIV-1 and wraps, pulsing o_tick on the terminal
// count. While i_restart is high the count is pinned at zero, so the first
// timed state after a restart lasts exactly CLK_DIV cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   i_restart  : hold the count at zero (no tick while high)
//   o_tick     : terminal-count pulse
// ---------------------------------------------------------------------------
module spi_half_period_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam logic [7:0] TERM_COUNT = 8'(CLK_DIV - 1);

  logic [7:0] r_count;
  logic       w_terminal;

  assign w_terminal = (r_count == TERM_COUNT);
  assign o_tick     = w_terminal && !i_restart;

  // Half-period counter: cleared on restart and on terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_restart || w_terminal) begin
      r_count <= 8'd0;
    end else begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: rtl/spi_cfg_controller.sv
// ---------------------------------------------------------------------------
// spi_cfg_controller
// SPI mode-0 initiator that turns register-write requests into 16-bit
// frames {write bit, address, data}, MSB first. A frame is SETUP (ncs low,
// first bit presented), 16 sclk periods of CLK_DIV high / CLK_DIV low, HOLD
// (ncs still low, sclk and copi low), then GAP (ncs high) before returning to
// IDLE with a one-cycle done pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request handshake, SPI pins and status (slave modport)
// ---------------------------------------------------------------------------
module spi_cfg_controller #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = spi_cfg_pkg::ADDR_W,
  parameter int DATA_W  = spi_cfg_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_cfg_controller_if.slave  bus
);

  import spi_cfg_pkg::*;

  localparam int         FRAME_W  = 1 + ADDR_W + DATA_W;
  localparam logic [4:0] LAST_BIT = 5'(FRAME_W);

  state_t             r_state;
  state_t             w_nextState;
  logic [FRAME_W-1:0] r_shift;
  logic [4:0]         r_bitCnt;
  logic               r_sclkHigh;
  logic               r_done;
  logic               w_tick;
  logic               w_accept;
  logic               w_restart;

  assign w_accept  = (r_state == IDLE) && bus.req_valid;
  assign w_restart = (r_state == IDLE);

  spi_half_period_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Every timed state ends on a timer tick; SHIFT only ends once the low
  // half of the last bit has elapsed, so sclk rises exactly FRAME_W times.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = SETUP;
      SETUP:   if (w_tick) w_nextState = SHIFT;
      SHIFT:   if (w_tick && !r_sclkHigh && (r_bitCnt == LAST_BIT)) w_nextState = HOLD;
      HOLD:    if (w_tick) w_nextState = GAP;
      GAP:     if (w_tick) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Frame datapath. The shift register advances on the falling sclk edge so
  // the next bit sits on copi a full half-period before the following rise.
  // Zeros shift in behind the data, so copi is already low by HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bitCnt   <= 5'd0;
      r_sclkHigh <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == GAP) && w_tick;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift    <= {WRITE_BIT, bus.req_addr, bus.req_data};
            r_bitCnt   <= 5'd0;
            r_sclkHigh <= 1'b0;
          end
        end
        SETUP: begin
          if (w_tick) r_sclkHigh <= 1'b1;
        end
        SHIFT: begin
          if (w_tick) begin
            if (r_sclkHigh) begin
              r_sclkHigh <= 1'b0;
              r_shift    <= {r_shift[FRAME_W-2:0], 1'b0};
              r_bitCnt   <= r_bitCnt + 5'd1;
            end else if (r_bitCnt != LAST_BIT) begin
              r_sclkHigh <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.ncs       = 1'b1;
    bus.sclk      = 1'b0;
    bus.copi      = 1'b0;
    bus.done      = r_done;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      SETUP: begin
        bus.ncs  = 1'b0;
        bus.copi = r_shift[FRAME_W-1];
      end
      SHIFT: begin
        bus.ncs  = 1'b0;
        bus.sclk = r_sclkHigh;
        bus.copi = r_shift[FRAME_W-1];
      end
      HOLD: begin
        bus.ncs = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_cfg_controller.sv
// ---------------------------------------------------------------------------
// tb_spi_cfg_controller
// Two controllers side by side (CLK_DIV=4 and CLK_DIV=2) on one clock and
// reset. A per-instance monitor decodes the SPI pins into frames and compares
// them, their timing and the status flags with a reference model built from
// the handshake: every accepted request is owed one frame of
// 0x8000 + addr*256 + data, with done exactly 35*CLK_DIV edges after accept.
// ---------------------------------------------------------------------------
module tb_spi_cfg_controller;

  import spi_cfg_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] reqValid = '0;
  logic [6:0] reqAddr [2];
  logic [7:0] reqData [2];
  logic [1:0] readyObs, sclkObs, ncsObs, copiObs, busyObs, doneObs;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gInst
    localparam int D = (g == 0) ? 4 : 2;

    spi_cfg_controller_if bus ();

    spi_cfg_controller #(
      .CLK_DIV (D)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.req_valid = reqValid[g];
    assign bus.req_addr  = reqAddr[g];
    assign bus.req_data  = reqData[g];
    assign readyObs[g]   = bus.req_ready;
    assign sclkObs[g]    = bus.sclk;
    assign ncsObs[g]     = bus.ncs;
    assign copiObs[g]    = bus.copi;
    assign busyObs[g]    = bus.busy;
    assign doneObs[g]    = bus.done;

    int          expQ[$];
    int          acceptEdge = -1;
    int          lastAccept = -1000000;
    int          accepts = 0, aborts = 0, framesEnded = 0, doneSeen = 0;
    int          phaseErr = 0, copiErr = 0, readyErr = 0, busyErr = 0, gapErr = 0;
    int          run = 0, ncsLowRun = 0, ncsHighRun = 1000, rxCnt = 0;
    logic [15:0] rxWord = '0, lastRx = '0;
    logic        pSclk = 1'b0, pNcs = 1'b1, pCopi = 1'b0;

    always @(negedge clk) begin
      if (!rst_n) begin
        if (acceptEdge >= 0) begin
          aborts++;
          expQ.delete();
        end
        acceptEdge = -1;
        lastAccept = -1000000;
        rxCnt      = 0;
        run        = 0;
        ncsHighRun = 1000;
        pSclk      = 1'b0;
        pNcs       = 1'b1;
        pCopi      = 1'b0;
      end else begin
        logic expBusy;
        expBusy = (acceptEdge >= 0) && (cyc >= acceptEdge) && (cyc < acceptEdge + 35 * D);
        if (busyObs[g] !== expBusy) busyErr++;
        if (readyObs[g] !== !expBusy) readyErr++;
        if (doneObs[g]) begin
          doneSeen++;
          checkOutput($sformatf("doneLatency%0d", g), cyc - lastAccept, 35 * D);
          acceptEdge = -1;
        end
        if (!ncsObs[g]) begin
          if (pNcs) begin
            if (framesEnded > 0 && ncsHighRun < D + 1) gapErr++;
            rxCnt     = 0;
            ncsLowRun = 0;
            run       = 1;
          end else if (sclkObs[g] != pSclk) begin
            if (run != D) phaseErr++;
            run = 1;
          end else begin
            run++;
          end
          if (!pNcs && copiObs[g] != pCopi && !(pSclk && !sclkObs[g])) copiErr++;
          if (sclkObs[g] && !pSclk) begin
            rxWord = {rxWord[14:0], copiObs[g]};
            rxCnt++;
          end
          ncsLowRun++;
        end else if (!pNcs) begin
          if (run != 2 * D) phaseErr++;
          checkOutput($sformatf("ncsLowLen%0d", g), ncsLowRun, 34 * D);
          checkOutput($sformatf("risingEdges%0d", g), rxCnt, 16);
          if (expQ.size() == 0) begin
            checkOutput($sformatf("unexpectedFrame%0d", g), rxWord, 32'hFFFF_FFFF);
          end else begin
            checkOutput($sformatf("frameWord%0d", g), rxWord, expQ.pop_front());
          end
          lastRx = rxWord;
          framesEnded++;
          ncsHighRun = 0;
        end
        if (ncsObs[g]) ncsHighRun++;
        if (reqValid[g] && readyObs[g]) begin
          acceptEdge = cyc + 1;
          lastAccept = cyc + 1;
          expQ.push_back(32768 + int'(reqAddr[g]) * 256 + int'(reqData[g]));
          accepts++;
        end
        pSclk = sclkObs[g];
        pNcs  = ncsObs[g];
        pCopi = copiObs[g];
      end
    end
  end

  // Presents one request and waits (bounded) for the edge that takes it.
  // With holdValid the request line stays up so the caller can queue the
  // next value immediately behind it.
  task automatic applyStimulus(input int idx, input logic [6:0] a, input logic [7:0] d, input bit holdValid);
    bit taken;
    reqValid[idx] = 1'b1;
    reqAddr[idx]  = a;
    reqData[idx]  = d;
    taken = 1'b0;
    for (int n = 0; n < 1000 && !taken; n++) begin
      @(negedge clk);
      taken = readyObs[idx] && rst_n;
      @(posedge clk);
      #1;
    end
    if (!taken) checkOutput($sformatf("acceptTimeout%0d", idx), 0, 1);
    if (!holdValid) reqValid[idx] = 1'b0;
    reqAddr[idx] = 7'($urandom);
    reqData[idx] = 8'($urandom);
  endtask

  task automatic waitIdle(input int idx);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 2000 && !idle; n++) begin
      @(negedge clk);
      idle = !busyObs[idx];
    end
    if (!idle) checkOutput($sformatf("idleTimeout%0d", idx), 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Junk requests while a frame is in flight must be ignored.
  task automatic pokeBusy(input int idx);
    reqValid[idx] = 1'b1;
    reqAddr[idx]  = 7'($urandom);
    reqData[idx]  = 8'($urandom);
    repeat ($urandom_range(1, 4)) begin
      @(posedge clk);
      #1;
    end
    reqValid[idx] = 1'b0;
  endtask

  task automatic randomTraffic(input int idx, input int n);
    for (int k = 0; k < n; k++) begin
      bit hold;
      hold = ($urandom_range(0, 3) == 0) && (k < n - 1);
      applyStimulus(idx, 7'($urandom), 8'($urandom), hold);
      if (!hold) begin
        if ($urandom_range(0, 1) == 1) pokeBusy(idx);
        waitIdle(idx);
        repeat ($urandom_range(0, 4)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      reqAddr[i] = 7'h55;
      reqData[i] = 8'h3C;
    end
    reqValid = 2'b11;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rstSclk%0d", i), sclkObs[i], 1'b0);
      checkOutput($sformatf("rstNcs%0d", i), ncsObs[i], 1'b1);
      checkOutput($sformatf("rstCopi%0d", i), copiObs[i], 1'b0);
      checkOutput($sformatf("rstReady%0d", i), readyObs[i], 1'b1);
      checkOutput($sformatf("rstBusy%0d", i), busyObs[i], 1'b0);
      checkOutput($sformatf("rstDone%0d", i), doneObs[i], 1'b0);
    end
    @(posedge clk);
    #1;
    reqValid = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rstNoAccept0", gInst[0].accepts, 0);
    checkOutput("rstNoAccept1", gInst[1].accepts, 0);

    $display("[TB] single write 0x04 <= 0xA5");
    applyStimulus(0, PWM_DUTY_CYCLE, 8'hA5, 1'b0);
    waitIdle(0);
    checkOutput("singleFrame", gInst[0].lastRx, 16'h84A5);

    $display("[TB] back-to-back writes");
    applyStimulus(0, EN_REG_OUT_7_0, 8'hFF, 1'b1);
    applyStimulus(0, EN_REG_OUT_15_8, 8'h0F, 1'b0);
    waitIdle(0);
    checkOutput("backToBackLast", gInst[0].lastRx, 16'h810F);

    $display("[TB] reset after the 7th rising edge");
    applyStimulus(0, 7'h33, 8'hC3, 1'b0);
    begin
      bit reached;
      reached = 1'b0;
      for (int n = 0; n < 400 && !reached; n++) begin
        @(negedge clk);
        reached = (gInst[0].rxCnt >= 7);
      end
      if (!reached) checkOutput("seventhEdgeTimeout", 0, 1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abortNcs", ncsObs[0], 1'b1);
    checkOutput("abortSclk", sclkObs[0], 1'b0);
    checkOutput("abortBusy", busyObs[0], 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(0, EN_REG_PWM_7_0, 8'h3C, 1'b0);
    waitIdle(0);
    checkOutput("afterAbortFrame", gInst[0].lastRx, 16'h823C);

    $display("[TB] randomized traffic on both dividers");
    fork
      randomTraffic(0, 6);
      randomTraffic(1, 12);
    join
    repeat (10) @(posedge clk);
    #1;

    checkOutput("aborts0", gInst[0].aborts, 1);
    checkOutput("aborts1", gInst[1].aborts, 0);
    checkOutput("frames0", gInst[0].framesEnded, gInst[0].accepts - gInst[0].aborts);
    checkOutput("frames1", gInst[1].framesEnded, gInst[1].accepts - gInst[1].aborts);
    checkOutput("dones0", gInst[0].doneSeen, gInst[0].accepts - gInst[0].aborts);
    checkOutput("dones1", gInst[1].doneSeen, gInst[1].accepts - gInst[1].aborts);
    checkOutput("pending0", gInst[0].expQ.size(), 0);
    checkOutput("pending1", gInst[1].expQ.size(), 0);
    checkOutput("phaseErr0", gInst[0].phaseErr, 0);
    checkOutput("phaseErr1", gInst[1].phaseErr, 0);
    checkOutput("copiErr0", gInst[0].copiErr, 0);
    checkOutput("copiErr1", gInst[1].copiErr, 0);
    checkOutput("readyErr0", gInst[0].readyErr, 0);
    checkOutput("readyErr1", gInst[1].readyErr, 0);
    checkOutput("busyErr0", gInst[0].busyErr, 0);
    checkOutput("busyErr1", gInst[1].busyErr, 0);
    checkOutput("gapErr0", gInst[0].gapErr, 0);
    checkOutput("gapErr1", gInst[1].gapErr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
